// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: RAW stalls the decode-stage forwarding cannot cover, redirect flushes, and data-memory freezes.
// Optional build macro HAZARD_PERF_EN adds saturating performance counters.
module hazard_controller #(
    parameter int         MEM_TIMEOUT = 255,
    parameter int         TIMEOUT_W   = 8,
    parameter logic [1:0] DEST_MEM    = 2'd1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [4:0] id_rs1_addr_i,
    input  logic       id_rs1_used_i,
    input  logic [4:0] id_rs2_addr_i,
    input  logic       id_rs2_used_i,
    input  logic [4:0] id_ex_reg_wr_addr_i,
    input  logic       id_ex_reg_wr_sig_i,
    input  logic [1:0] id_ex_data_dest_i,
    input  logic [4:0] ex_mem_reg_wr_addr_i,
    input  logic       ex_mem_reg_wr_sig_i,
    input  logic [1:0] ex_mem_data_dest_i,
    input  logic       ex_redirect_i,
    input  logic       mem_req_i,
    input  logic       mem_ack_i,
    output logic       pc_stall_o,
    output logic       if_id_stall_o,
    output logic       if_id_flush_o,
    output logic       id_ex_stall_o,
    output logic       id_ex_flush_o,
    output logic       ex_mem_stall_o,
    output logic       mem_wb_flush_o,
    output logic       mem_timeout_o,
    output logic [1:0] state_o
`ifdef HAZARD_PERF_EN
   ,output logic [31:0] perf_raw_stall_o,
    output logic [31:0] perf_flush_o,
    output logic [31:0] perf_mem_wait_o
`endif
);

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_RAW  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [1:0]           raw_cnt_q, raw_cnt_d;
    logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                 timeout_q, timeout_d;

    logic       ex_hit, mem_load_hit, timeout_hit, freeze;
    logic [1:0] need;

    always_comb begin
        ex_hit = id_ex_reg_wr_sig_i && (id_ex_reg_wr_addr_i != 5'd0) &&
                 ((id_rs1_used_i && (id_rs1_addr_i == id_ex_reg_wr_addr_i)) ||
                  (id_rs2_used_i && (id_rs2_addr_i == id_ex_reg_wr_addr_i)));
        mem_load_hit = ex_mem_reg_wr_sig_i && (ex_mem_reg_wr_addr_i != 5'd0) &&
                       (ex_mem_data_dest_i == DEST_MEM) &&
                       ((id_rs1_used_i && (id_rs1_addr_i == ex_mem_reg_wr_addr_i)) ||
                        (id_rs2_used_i && (id_rs2_addr_i == ex_mem_reg_wr_addr_i)));
        need = 2'd0;
        if (ex_hit)
            need = (id_ex_data_dest_i == DEST_MEM) ? 2'd2 : 2'd1;
        else if (mem_load_hit)
            need = 2'd1;
        // The cycle that hits the limit releases the pipeline as if acked.
        timeout_hit = (state_q == ST_WAIT) && (wait_cnt_q == TIMEOUT_W'(MEM_TIMEOUT - 1)) &&
                      mem_req_i && !mem_ack_i;
        freeze = mem_req_i && !mem_ack_i && !timeout_hit;
    end

    always_comb begin
        state_d    = state_q;
        raw_cnt_d  = raw_cnt_q;
        wait_cnt_d = freeze ? wait_cnt_q + 1'b1 : '0;
        timeout_d  = timeout_q | timeout_hit;
        case (state_q)
            ST_RUN: begin
                if (freeze) begin
                    state_d = ST_WAIT;
                end else if (!ex_redirect_i && (need == 2'd2)) begin
                    state_d   = ST_RAW;
                    raw_cnt_d = 2'd1;
                end
            end
            ST_RAW: begin
                if (freeze) begin
                    state_d = ST_WAIT;
                end else if (ex_redirect_i) begin
                    state_d   = ST_RUN;
                    raw_cnt_d = 2'd0;
                end else begin
                    raw_cnt_d = raw_cnt_q - 1'b1;
                    if (raw_cnt_q <= 2'd1)
                        state_d = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (!freeze) begin
                    if (ex_redirect_i) begin
                        state_d   = ST_RUN;
                        raw_cnt_d = 2'd0;
                    end else begin
                        state_d = (raw_cnt_q != 2'd0) ? ST_RAW : ST_RUN;
                    end
                end
            end
            default: begin
                state_d   = ST_RUN;
                raw_cnt_d = 2'd0;
            end
        endcase
    end

    // Outputs are gated by reset so they drop without waiting for a clock.
    always_comb begin
        pc_stall_o     = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        mem_wb_flush_o = 1'b0;
        if (rst_n_i) begin
            if (freeze) begin
                pc_stall_o     = 1'b1;
                if_id_stall_o  = 1'b1;
                id_ex_stall_o  = 1'b1;
                ex_mem_stall_o = 1'b1;
                mem_wb_flush_o = 1'b1;
            end else if (ex_redirect_i) begin
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end else if ((state_q == ST_RAW) || ((state_q == ST_RUN) && (need != 2'd0))) begin
                pc_stall_o    = 1'b1;
                if_id_stall_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_RUN;
            raw_cnt_q  <= 2'd0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            raw_cnt_q  <= raw_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign mem_timeout_o = timeout_q;
    assign state_o       = state_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_raw_q, perf_raw_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_mem_q, perf_mem_d;

    always_comb begin
        perf_raw_d   = perf_raw_q;
        perf_flush_d = perf_flush_q;
        perf_mem_d   = perf_mem_q;
        if (pc_stall_o && !freeze && (perf_raw_q != 32'hFFFF_FFFF))
            perf_raw_d = perf_raw_q + 32'd1;
        if (if_id_flush_o && (perf_flush_q != 32'hFFFF_FFFF))
            perf_flush_d = perf_flush_q + 32'd1;
        if (freeze && (perf_mem_q != 32'hFFFF_FFFF))
            perf_mem_d = perf_mem_q + 32'd1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            perf_raw_q   <= 32'd0;
            perf_flush_q <= 32'd0;
            perf_mem_q   <= 32'd0;
        end else begin
            perf_raw_q   <= perf_raw_d;
            perf_flush_q <= perf_flush_d;
            perf_mem_q   <= perf_mem_d;
        end
    end

    assign perf_raw_stall_o = perf_raw_q;
    assign perf_flush_o     = perf_flush_q;
    assign perf_mem_wait_o  = perf_mem_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios then random traffic against a cycle-level reference model.
module tb_hazard_controller;

    localparam int TMO = 4;
    localparam logic [1:0] D_ALU = 2'd0, D_MEM = 2'd1, D_PC = 2'd2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs1 = '0, rs2 = '0, ie_rd = '0, em_rd = '0;
    logic       rs1_u = 1'b0, rs2_u = 1'b0, ie_wr = 1'b0, em_wr = 1'b0;
    logic [1:0] ie_dest = '0, em_dest = '0;
    logic       redir = 1'b0, req = 1'b0, ack = 1'b0;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic       ex_mem_stall, mem_wb_flush, mem_timeout;
    logic [1:0] state;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_raw, perf_flush, perf_mem;
`endif

    int vectors = 0;
    int miscompares = 0;

    // reference model: stall cycles still owed, memory wait in progress and its length, sticky timeout
    int pending = 0;
    bit in_wait = 1'b0;
    int waited = 0;
    bit sticky = 1'b0;

    hazard_controller #(.MEM_TIMEOUT(TMO), .TIMEOUT_W(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .id_rs1_addr_i(rs1), .id_rs1_used_i(rs1_u),
        .id_rs2_addr_i(rs2), .id_rs2_used_i(rs2_u),
        .id_ex_reg_wr_addr_i(ie_rd), .id_ex_reg_wr_sig_i(ie_wr), .id_ex_data_dest_i(ie_dest),
        .ex_mem_reg_wr_addr_i(em_rd), .ex_mem_reg_wr_sig_i(em_wr), .ex_mem_data_dest_i(em_dest),
        .ex_redirect_i(redir), .mem_req_i(req), .mem_ack_i(ack),
        .pc_stall_o(pc_stall), .if_id_stall_o(if_id_stall), .if_id_flush_o(if_id_flush),
        .id_ex_stall_o(id_ex_stall), .id_ex_flush_o(id_ex_flush),
        .ex_mem_stall_o(ex_mem_stall), .mem_wb_flush_o(mem_wb_flush),
        .mem_timeout_o(mem_timeout), .state_o(state)
`ifdef HAZARD_PERF_EN
       ,.perf_raw_stall_o(perf_raw), .perf_flush_o(perf_flush), .perf_mem_wait_o(perf_mem)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit reads(logic [4:0] rd);
        return (rd != 5'd0) && ((rs1_u && rs1 == rd) || (rs2_u && rs2 == rd));
    endfunction

    function automatic int need_of();
        if (ie_wr && reads(ie_rd)) return (ie_dest == D_MEM) ? 2 : 1;
        if (em_wr && em_dest == D_MEM && reads(em_rd)) return 1;
        return 0;
    endfunction

    function automatic logic [9:0] observed();
        return {state, mem_timeout, pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                id_ex_flush, ex_mem_stall, mem_wb_flush};
    endfunction

    task automatic model_reset();
        pending = 0; in_wait = 1'b0; waited = 0; sticky = 1'b0;
    endtask

    // Called one time unit after a rising edge with inputs already applied.
    task automatic step(string tag);
        int n;
        bit tmo, frz;
        logic [6:0] e7;
        logic [1:0] es;
        n   = need_of();
        tmo = in_wait && (waited == TMO - 1) && req && !ack;
        frz = req && !ack && !tmo;
        es  = in_wait ? 2'd2 : (pending > 0 ? 2'd1 : 2'd0);
        if (frz)               e7 = 7'b1101011;
        else if (redir)        e7 = 7'b0010100;
        else if (in_wait)      e7 = 7'b0000000;
        else if (pending > 0)  e7 = 7'b1100100;
        else if (n > 0)        e7 = 7'b1100100;
        else                   e7 = 7'b0000000;
        #4;
        chk(tag, 16'(observed()), 16'({es, sticky, e7}));
        if (frz) begin
            in_wait = 1'b1;
            waited++;
        end else begin
            if (tmo) sticky = 1'b1;
            if (redir) pending = 0;
            else if (!in_wait) begin
                if (pending > 0) pending--;
                else if (n == 2) pending = 1;
            end
            in_wait = 1'b0;
            waited  = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1 = '0; rs2 = '0; ie_rd = '0; em_rd = '0;
        rs1_u = 0; rs2_u = 0; ie_wr = 0; em_wr = 0;
        ie_dest = D_ALU; em_dest = D_ALU;
        redir = 0; req = 0; ack = 0;
    endtask

    task automatic load_use();
        clear_inputs();
        ie_rd = 5'd5; ie_wr = 1; ie_dest = D_MEM;
        rs1 = 5'd5; rs1_u = 1;
    endtask

    initial begin
        // reset held with a freeze request present: outputs must stay quiet
        req = 1;
        #7;
        chk("reset_outputs", 16'(observed()), 16'd0);
        clear_inputs();
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        model_reset();

        // load-use: lw x5 in ID/EX, add reads x5
        load_use();
        step("lu_c1");
        chk("lu_state_raw", 16'(state), 16'd1);
        clear_inputs();
        em_rd = 5'd5; em_wr = 1; em_dest = D_MEM; rs1 = 5'd5; rs1_u = 1;
        step("lu_c2");
        clear_inputs(); rs1 = 5'd5; rs1_u = 1;
        step("lu_c3_none");
        chk("lu_state_back", 16'(state), 16'd0);

        // ALU producer read via rs2, then rd = x0
        clear_inputs();
        ie_rd = 5'd7; ie_wr = 1; ie_dest = D_ALU; rs2 = 5'd7; rs2_u = 1;
        step("alu_rs2_stall");
        ie_wr = 0; em_rd = 5'd7; em_wr = 1; em_dest = D_ALU;
        step("alu_rs2_fwd");
        clear_inputs();
        ie_rd = 5'd0; ie_wr = 1; rs2 = 5'd0; rs2_u = 1;
        step("x0_no_stall");
        chk("x0_pc_stall", 16'(pc_stall), 16'd0);

        // pending RAW cycle survives a 3-cycle memory wait
        load_use();
        step("mw_raw_first");
        clear_inputs(); req = 1;
        step("mw_frz1");
        step("mw_frz2");
        step("mw_frz3");
        ack = 1;
        step("mw_ack");
        chk("mw_resume_state", 16'(state), 16'd1);
        clear_inputs();
        step("mw_raw_resume");
        step("mw_idle");

        // redirect wins over load-use
        load_use(); redir = 1;
        step("redir_over_raw");
        clear_inputs();
        step("redir_after");

        // memory timeout
        req = 1;
        step("to_frz1");
        step("to_frz2");
        step("to_frz3");
        step("to_release");
        chk("to_sticky", 16'(mem_timeout), 16'd1);
        clear_inputs();
        step("to_after_run");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
            ie_rd = 5'($urandom_range(0, 3)); em_rd = 5'($urandom_range(0, 3));
            rs1_u = 1'($urandom); rs2_u = 1'($urandom);
            ie_wr = 1'($urandom); em_wr = 1'($urandom);
            ie_dest = 2'($urandom_range(0, 2)); em_dest = 2'($urandom_range(0, 2));
            redir = ($urandom_range(0, 9) == 0);
            req   = ($urandom_range(0, 9) < 3);
            ack   = 1'($urandom);
            step("random");
        end

        // asynchronous reset while in RAW_STALL
        clear_inputs();
        step("pre_rst_idle");
        load_use();
        step("rst_raw_enter");
        clear_inputs();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", 16'(observed()), 16'd0);
        model_reset();
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        step("rst_post_run");
        chk("rst_post_state", 16'(state), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Sequences the 5-stage pipeline around the decode-stage forwarding unit.
- Inserts stall cycles when forwarding cannot cover a RAW dependency, flushes after EX redirects, and freezes the pipeline while data memory is busy.
- Sits beside decode and drives stall/flush enables of PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Decode-stage forwarding covers ALU/PC results from EX/MEM and ALU/MEM/PC results from MEM/WB. It does not cover the producer currently in ID/EX, or MEM data in EX/MEM.

Parameters:
MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before forced release
TIMEOUT_W, 8, width of wait counter (must hold MEM_TIMEOUT)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
id_rs1_addr_i  in  5  rs1 of instruction in ID
id_rs1_used_i  in  1  ID instruction reads rs1
id_rs2_addr_i  in  5  rs2 of instruction in ID
id_rs2_used_i  in  1  ID instruction reads rs2
id_ex_reg_wr_addr_i  in  5  rd of instruction in ID/EX
id_ex_reg_wr_sig_i  in  1  ID/EX writes rd
id_ex_data_dest_i  in  2  ID/EX writeback source (ALU/MEM/PC codes from parameters.vh)
ex_mem_reg_wr_addr_i  in  5  rd in EX/MEM
ex_mem_reg_wr_sig_i  in  1  EX/MEM writes rd
ex_mem_data_dest_i  in  2  EX/MEM writeback source
ex_redirect_i  in  1  EX resolved taken branch/jump this cycle
mem_req_i  in  1  MEM-stage instruction accesses data memory this cycle
mem_ack_i  in  1  data memory completes access this cycle
pc_stall_o  out  1  hold PC
if_id_stall_o  out  1  hold IF/ID
if_id_flush_o  out  1  clear IF/ID to NOP
id_ex_stall_o  out  1  hold ID/EX
id_ex_flush_o  out  1  load bubble into ID/EX
ex_mem_stall_o  out  1  hold EX/MEM
mem_wb_flush_o  out  1  load bubble into MEM/WB
mem_timeout_o  out  1  sticky: a memory wait timed out
state_o  out  2  FSM state: 0 RUN, 1 RAW_STALL, 2 MEM_WAIT

Behaviour:
- Reset (async, rst_n_i low):
  - State RUN, raw_cnt=0, wait_cnt=0, mem_timeout_o=0.
  - All stall/flush outputs are 0. They are combinational from state and inputs, with the same-cycle effect required by the pipeline registers.
- RAW detect, evaluated only in RUN. Matches require rd≠0, write sig high and the source's used flag set:
  - Match on ID/EX producer: need 2 if dest==MEM, else 1.
  - Else match on EX/MEM producer with dest==MEM: need 1.
  - Otherwise need 0.
- Freeze condition: mem_req_i && !mem_ack_i while not timed out.
  - In any state, a freeze asserts pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_flush; all other outputs are 0.
  - From RUN or RAW_STALL the FSM moves to MEM_WAIT; raw_cnt is held.
- Priority: freeze > ex_redirect_i > RAW stall.
- RUN:
  - Redirect: if_id_flush=1 and id_ex_flush=1. The RAW hazard is ignored because the consumer is squashed.
  - Need≥1: pc_stall=1, if_id_stall=1, id_ex_flush=1. If need==2, go to RAW_STALL with raw_cnt=1.
- RAW_STALL:
  - Asserts pc_stall, if_id_stall and id_ex_flush, decrements raw_cnt, and returns to RUN when raw_cnt reaches 0. Detection is not re-evaluated.
  - A redirect here flushes IF/ID and ID/EX, clears raw_cnt and goes to RUN.
- MEM_WAIT:
  - wait_cnt increments each cycle.
  - mem_ack_i high: no freeze that cycle; go to RAW_STALL if raw_cnt≠0, else RUN; wait_cnt clears.
  - wait_cnt==MEM_TIMEOUT−1 without ack: mem_timeout_o set (sticky until reset); treated as ack that cycle; same exit as ack.
- mem_ack_i without mem_req_i is ignored.
- Reset mid-operation: aborts immediately; all outputs 0 asynchronously.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds three 32-bit saturating outputs, all reset to 0:
  - perf_raw_stall_o: counts cycles with a RAW stall.
  - perf_flush_o: counts redirect flush events.
  - perf_mem_wait_o: counts freeze cycles.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- ID/EX lw x5, ID add reads x5 (rs1) → 2 cycles of pc_stall/if_id_stall/id_ex_flush, state_o 0→1→0.
- ID/EX addi x7, ID reads x7 via rs2 → exactly 1 stall cycle; the same pattern with rd=x0 → no stall.
- mem_req_i=1, ack after 3 cycles → ex_mem_stall and mem_wb_flush high 3 cycles, low on the ack cycle; a raw_cnt=1 stall pending before MEM_WAIT resumes after exit.
- ex_redirect_i in the same cycle as an ID/EX load-use match → if_id_flush=1, id_ex_flush=1, pc_stall=0, state stays RUN.
- mem_req_i held, no ack, MEM_TIMEOUT=4 → freeze 3 cycles, mem_timeout_o=1 on the 4th, FSM returns to RUN, flag persists until rst_n_i low.
- rst_n_i pulsed low while in RAW_STALL → outputs 0 asynchronously, state_o=0 after release.
